// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use bubbles, taken-branch
// squash, halt drain, plus saturating stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_halt_req,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDrain  = 2'd1,
      StHalted = 2'd2
   } state_e;

   localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       drain_q, drain_d;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_inc, flush_inc;
   logic             lu;

   assign lu = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      case (state_q)
         StRun: begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            // A taken branch makes the ID instruction wrong-path, so it masks lu and halt.
            if (ex_branch_taken) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               flush_inc   = 1'b1;
            end else if (lu) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               stall_inc   = 1'b1;
            end else if (id_halt_req) begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               state_d     = StDrain;
               drain_d     = DrainInit;
            end
         end
         StDrain: begin
            if_id_write = 1'b1;
            if (drain_q == 4'd0) begin
               state_d = StHalted;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         default: ; // HALTED and the unused encoding hold with everything frozen
      endcase
      if (!reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StRun;
         drain_q <= 4'd0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   // Encodings 2 and 3 both count as halted; bit 1 covers exactly those.
   assign halted       = state_q[1];
   assign state        = state_q;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

endmodule
